onehot_rr_arbiter: RTL and testbench
====================================

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

Interface
REQ-001 Parameter BITS, default 9, number of requesters; range 2..16.
REQ-002 Parameter IDXW, default 4, width of binary grant index; SHALL satisfy 2**IDXW >= BITS.
REQ-003 Parameter MAX_HOLD, default 16, maximum grant duration in cycles; range 2..255.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req  input  BITS  request vector, bit k = requester k wants the resource.
REQ-007 i_done  input  1  current owner finished; sampled only in GRANT.
REQ-008 o_grant  output  BITS  registered one-hot grant; all-zero when no owner.
REQ-009 o_grant_idx  output  IDXW  registered binary index of owner; 0 when no owner.
REQ-010 o_busy  output  1  high while in GRANT.
REQ-011 o_timeout  output  1  single-cycle pulse on forced release.

Function
REQ-012 FSM states: IDLE, GRANT; two states only.
REQ-013 IDLE: if i_req != 0 at edge t, go to GRANT; o_grant, o_grant_idx, o_busy valid from edge t (visible in cycle t+1).
REQ-014 IDLE with i_req == 0: stay IDLE; outputs all zero.
REQ-015 Winner selection: round-robin; search starts at index ptr, ascending, wraps BITS-1 -> 0; first set i_req bit wins.
REQ-016 ptr reset value 0; on each grant ptr <= (winner + 1) mod BITS; winner BITS-1 -> ptr 0.
REQ-017 o_grant SHALL be exactly one-hot in GRANT and zero in IDLE; o_grant[o_grant_idx] == 1 in GRANT.
REQ-018 GRANT: hold counter cleared at grant, increments every GRANT cycle.
REQ-019 GRANT -> IDLE on first edge where i_done == 1 OR i_req[owner] == 0; outputs cleared at that edge.
REQ-020 GRANT -> IDLE forced when hold counter reaches MAX_HOLD-1 without release; o_timeout = 1 for the following cycle only.
REQ-021 Simultaneous i_done and timeout on same edge: treated as normal release, o_timeout stays 0.
REQ-022 Requests changing in GRANT ignored except owner's bit (REQ-019); no preemption.
REQ-023 Minimum one IDLE cycle between consecutive grants; max grant length MAX_HOLD cycles.
REQ-024 i_done in IDLE ignored.
REQ-025 Fairness: with all BITS requesters continuously asserting, each receives exactly one grant per BITS grants.

Reset
REQ-026 i_rst high: immediately (no clock needed) state = IDLE, ptr = 0, hold counter = 0, o_grant = 0, o_grant_idx = 0, o_busy = 0, o_timeout = 0.
REQ-027 Reset asserted mid-GRANT: grant dropped asynchronously; no o_timeout pulse generated.
REQ-028 First edge after i_rst deassert behaves as IDLE evaluation with ptr = 0.

Verification
REQ-029 Reset, then i_req = 9'b000010100 -> next cycle o_grant = 9'b000000100, o_grant_idx = 2, o_busy = 1; ptr becomes 3.
REQ-030 From REQ-029, i_done = 1 one cycle -> o_grant = 0 next cycle; with i_req unchanged next grant idx 4, then idx 2 (wrap via 8 -> 0).
REQ-031 i_req = 9'h1FF held, i_done pulsed each grant -> grant index sequence 0,1,...,8,0; one IDLE cycle between grants.
REQ-032 Single request bit 5 held, i_done never asserted -> o_busy high exactly 16 cycles, then o_timeout pulse 1 cycle, o_grant = 0; regrant to 5 one cycle later.
REQ-033 Owner 3 granted, i_req[3] drops with i_done = 0 -> release next edge, o_timeout = 0.
REQ-034 Assert i_rst mid-grant between clock edges -> o_grant, o_busy go 0 without clock; after release, i_req = 9'b100000001 grants idx 0.

Source files
------------

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter
// Round-robin arbiter with a two-state IDLE/GRANT controller. A grant is held
// until the owner signals done, withdraws its request, or the hold limit
// expires (forced release, flagged by a one-cycle o_timeout pulse).
// Grant vector, grant index, busy and timeout are all registered outputs.

module onehot_rr_arbiter #(
    parameter int BITS     = 9,
    parameter int IDXW     = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_req,
    input  logic            i_done,
    output logic [BITS-1:0] o_grant,
    output logic [IDXW-1:0] o_grant_idx,
    output logic            o_busy,
    output logic            o_timeout
);

    localparam int HOLDW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_r;
    logic [IDXW-1:0]   ptr_r;
    logic [HOLDW-1:0]  hold_r;

    logic [BITS-1:0]   rot_s;
    logic [IDXW-1:0]   off_s;
    logic [IDXW:0]     sum_s;
    logic [IDXW-1:0]   win_s;
    logic [IDXW-1:0]   ptr_next_s;
    logic              owner_req_s;
    logic [BITS-1:0]   win_onehot_s;

    // Round-robin winner search: rotate requests so ptr sits at bit 0, take the lowest set bit, then undo the rotation.
    always_comb begin
        rot_s = BITS'({i_req, i_req} >> ptr_r);
        off_s = '0;
        for (int k = BITS - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                off_s = IDXW'(k);
            end else begin
                off_s = off_s;
            end
        end
        sum_s = {1'b0, ptr_r} + {1'b0, off_s};
        if (sum_s >= (IDXW + 1)'(BITS)) begin
            win_s = IDXW'(sum_s - (IDXW + 1)'(BITS));
        end else begin
            win_s = IDXW'(sum_s);
        end
        if (win_s == IDXW'(BITS - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = win_s + IDXW'(1);
        end
        win_onehot_s = {{(BITS - 1){1'b0}}, 1'b1} << win_s;
    end

    // The owner is still requesting when its own bit of i_req remains set.
    assign owner_req_s = |(i_req & o_grant);

    // Controller: grant in IDLE, hold / release / forced timeout in GRANT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            hold_r      <= '0;
            o_grant     <= '0;
            o_grant_idx <= '0;
            o_busy      <= 1'b0;
            o_timeout   <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (|i_req) begin
                        state_r     <= GRANT;
                        o_grant     <= win_onehot_s;
                        o_grant_idx <= win_s;
                        o_busy      <= 1'b1;
                        ptr_r       <= ptr_next_s;
                        hold_r      <= '0;
                    end else begin
                        o_grant     <= '0;
                        o_grant_idx <= '0;
                        o_busy      <= 1'b0;
                    end
                end
                GRANT: begin
                    // Normal release takes priority over a coincident timeout.
                    if (i_done || !owner_req_s) begin
                        state_r     <= IDLE;
                        o_grant     <= '0;
                        o_grant_idx <= '0;
                        o_busy      <= 1'b0;
                        hold_r      <= '0;
                    end else if (hold_r == HOLDW'(MAX_HOLD - 1)) begin
                        state_r     <= IDLE;
                        o_grant     <= '0;
                        o_grant_idx <= '0;
                        o_busy      <= 1'b0;
                        hold_r      <= '0;
                        o_timeout   <= 1'b1;
                    end else begin
                        hold_r <= hold_r + HOLDW'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    o_grant     <= '0;
                    o_grant_idx <= '0;
                    o_busy      <= 1'b0;
                    hold_r      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Testbench for onehot_rr_arbiter: directed scenarios plus randomized traffic,
// all checked cycle by cycle against an integer-level reference model.

module tb_onehot_rr_arbiter;

    localparam int BITS     = 9;
    localparam int IDXW     = 4;
    localparam int MAX_HOLD = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] req = '0;
    logic            done = 1'b0;
    logic [BITS-1:0] grant;
    logic [IDXW-1:0] grant_idx;
    logic            busy;
    logic            timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: owner = -1 means nobody holds the resource.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_hold  = 0;
    bit m_timeout = 1'b0;

    onehot_rr_arbiter #(.BITS(BITS), .IDXW(IDXW), .MAX_HOLD(MAX_HOLD)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req       (req),
        .i_done      (done),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_ptr     = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic model_edge();
        bit to = 1'b0;
        if (m_owner < 0) begin
            if (req != '0) begin
                for (int k = 0; k < BITS; k++) begin
                    int c = (m_ptr + k) % BITS;
                    if (req[c] && m_owner < 0) m_owner = c;
                end
                m_ptr  = (m_owner + 1) % BITS;
                m_hold = 0;
            end
        end else if (done || !req[m_owner]) begin
            m_owner = -1;
        end else if (m_hold == MAX_HOLD - 1) begin
            m_owner = -1;
            to      = 1'b1;
        end else begin
            m_hold++;
        end
        m_timeout = to;
    endtask

    task automatic check_outputs(input string tag);
        logic [BITS-1:0] exp_grant = '0;
        int exp_idx = 0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            exp_idx = m_owner;
        end
        check_val({tag, "_grant"},   32'(grant),     32'(exp_grant));
        check_val({tag, "_idx"},     32'(grant_idx), 32'(exp_idx));
        check_val({tag, "_busy"},    32'(busy),      32'(m_owner >= 0));
        check_val({tag, "_timeout"}, 32'(timeout),   32'(m_timeout));
    endtask

    // One clock: drive inputs (called just after a falling edge), update the model at the rising edge, check 1 unit later.
    task automatic cycle(input logic [BITS-1:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    // Assert reset between edges, verify the asynchronous clear, release on a later falling edge.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int busy_cnt;
    int to_cnt;
    logic [BITS-1:0] rnd_req;

    initial begin
        @(negedge clk);
        do_reset("reset0");

        // Basic grant from two requesters, then wrap-around order 2 -> 4 -> 2.
        cycle(9'b000010100, 1'b0, "g2");
        check_val("g2_idx_const", 32'(grant_idx), 32'd2);
        cycle(9'b000010100, 1'b1, "rel_a");
        cycle(9'b000010100, 1'b0, "g4");
        check_val("g4_idx_const", 32'(grant_idx), 32'd4);
        cycle(9'b000010100, 1'b1, "rel_b");
        cycle(9'b000010100, 1'b0, "g2b");
        check_val("g2b_idx_const", 32'(grant_idx), 32'd2);
        cycle(9'b000010100, 1'b1, "rel_c");

        // Fairness: all requesting, done pulsed on each grant cycle.
        do_reset("reset_fair");
        for (int i = 0; i < 2 * (BITS + 1); i++) begin
            cycle(9'h1FF, 1'(i % 2), "fair");
            if (i % 2 == 0) check_val("fair_seq", 32'(grant_idx), 32'((i / 2) % BITS));
        end

        // Hold timeout: single requester 5, never done.
        do_reset("reset_to");
        busy_cnt = 0;
        to_cnt   = 0;
        for (int i = 0; i < MAX_HOLD + 1; i++) begin
            cycle(9'b000100000, 1'b0, "hold");
            busy_cnt += int'(busy);
            to_cnt   += int'(timeout);
        end
        check_val("hold_busy_cycles", 32'(busy_cnt), 32'(MAX_HOLD));
        check_val("hold_timeout_pulses", 32'(to_cnt), 32'd1);
        cycle(9'b000100000, 1'b0, "regrant5");
        check_val("regrant5_idx", 32'(grant_idx), 32'd5);
        cycle(9'b000100000, 1'b0, "to_clear");

        // Owner withdraws its request without done.
        do_reset("reset_drop");
        cycle(9'b000001000, 1'b0, "own3");
        cycle(9'b000000000, 1'b0, "drop3");

        // Reset in the middle of a grant, then restart from ptr 0.
        cycle(9'b000001000, 1'b0, "own3b");
        do_reset("mid_reset");
        cycle(9'b100000001, 1'b0, "post_rst");
        check_val("post_rst_idx", 32'(grant_idx), 32'd0);

        // Randomized traffic with sticky requests so long holds and timeouts occur.
        rnd_req = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) rnd_req = BITS'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd_reset");
            end else begin
                cycle(rnd_req, ($urandom_range(0, 11) == 0), "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
